aes_state_round_ctrl: RTL and testbench
=======================================

Name: aes_state_round_ctrl

Overview:
- Sequencer for the 4x4-byte AES state memory, which provides byte read, S-box write, ShiftRows and MixColumns commands.
- Per round, it loads 16 input bytes through the S-box write path and issues ShiftRows. It then issues MixColumns, except on the final round, and streams the 16 result bytes out with valid/ready backpressure.
- Sits between the round-key/XOR front end and the state memory.

Parameters:
- TIMEOUT, 0, maximum consecutive idle cycles allowed in LOAD or OUT before the round aborts with err; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; TIMEOUT must be less than 2^CNT_W.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begins a round; sampled only in IDLE.
- last_round  in  1  sampled with start; 1 skips MixColumns.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte, column-major order (byte k = row k%4, col k/4).
- in_ready  out  1  high in LOAD.
- out_valid  out  1  output byte valid.
- out_data  out  8  output byte, column-major order.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the 16th output handshake.
- err  out  1  one-cycle pulse on watchdog abort.
- mem_cs  out  1  state memory chip select.
- mem_rwsm  out  2  state memory command: 00 read, 01 write, 10 shift, 11 mix.
- mem_add  out  4  state memory address {row[1:0], col[1:0]}.
- mem_din  out  8  state memory write data.
- mem_dout  in  8  state memory registered read data; it changes only on the edge that executes a read.

Behaviour:
- States: IDLE, LOAD, SHIFT, MIX, READ, OUT.
- Reset (RST=1 at an edge):
  - state=IDLE, byte counter k=0, watchdog=0, last_round flag=0, done=0, err=0.
  - Combinational outputs then settle to in_ready=0, out_valid=0, busy=0, mem_cs=0, mem_rwsm=00, mem_add=0, mem_din=0.
  - Reset mid-round abandons the round with no done; memory contents are don't-care.
- IDLE: when start=1, latch last_round, set k=0, go to LOAD. Otherwise remain.
- LOAD:
  - in_ready=1.
  - Each in_valid handshake drives, in that same cycle: mem_cs=1, mem_rwsm=01, mem_din=in_data, mem_add={k[1:0],k[3:2]}.
  - k increments per handshake. After the handshake with k=15, go to SHIFT with k=0.
  - No handshake means mem_cs=0.
- SHIFT: exactly 1 cycle with mem_cs=1, mem_rwsm=10. Next state is MIX if latched last_round=0, else READ.
- MIX: exactly 1 cycle with mem_cs=1, mem_rwsm=11. Next state READ.
- READ: 1 cycle with mem_cs=1, mem_rwsm=00, mem_add={k[1:0],k[3:2]}. Next state OUT.
- OUT:
  - out_valid=1, out_data=mem_dout (combinational pass-through; mem_dout is stable because no read is issued in OUT). mem_cs=0.
  - On the out_ready handshake: if k=15, pulse done on the next cycle, k=0, go to IDLE. Otherwise k++, go to READ.
- Output throughput is 2 cycles per byte minimum. out_valid, once high, never drops before its handshake except on watchdog abort or reset.
- Latency: the first out_valid rises 3 cycles after the 16th load handshake with MixColumns (SHIFT, MIX, READ), or 2 cycles without it.
- Watchdog (TIMEOUT>0):
  - Counts consecutive cycles in LOAD without in_valid, or in OUT without out_ready; clears on any handshake or state change.
  - On reaching TIMEOUT: err pulses for 1 cycle, state goes to IDLE, k=0, no done.
- start asserted while busy is ignored. in_valid outside LOAD is ignored and in_ready=0 there.
- done and err are never asserted in the same cycle.

Test Plan:
- Full round: start, last_round=0; feed 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> outputs 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, then a single done pulse.
- Final round: same input with last_round=1 -> outputs d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5; no cycle has mem_rwsm=11 with mem_cs=1.
- Backpressure: run the full round with out_ready toggling randomly and in_valid gapped -> identical byte sequence, no duplicated or skipped bytes, out_data stable while out_valid=1 and out_ready=0.
- Command trace: check the exact sequence of 16 writes with addresses 0,4,8,12,1,5,...,15, then 10, 11, then 16 reads in the same address order; mem_cs=0 in every other cycle.
- Reset/abort: assert RST after the 7th load byte -> next cycle busy=0, in_ready=0, no done; a subsequent full round passes. With TIMEOUT=5 and in_valid held low in LOAD -> err pulses after 5 idle cycles, then IDLE.
- Ignored start: pulse start while busy in OUT -> no restart; round completes normally with exactly one done.

Source files
------------

// File: rtl/aes_state_round_ctrl_if.sv
// Handshake, status and state-memory command bundle for the AES round sequencer.
interface aes_state_round_ctrl_if;
    logic       start;
    logic       last_round;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       mem_cs;
    logic [1:0] mem_rwsm;
    logic [3:0] mem_add;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    modport slave (
        input  start, last_round, in_valid, in_data, out_ready, mem_dout,
        output in_ready, out_valid, out_data, busy, done, err,
               mem_cs, mem_rwsm, mem_add, mem_din
    );

    modport master (
        output start, last_round, in_valid, in_data, out_ready, mem_dout,
        input  in_ready, out_valid, out_data, busy, done, err,
               mem_cs, mem_rwsm, mem_add, mem_din
    );
endinterface

// File: rtl/aes_state_round_ctrl.sv
// Round sequencer for the 4x4-byte AES state memory: S-box load, ShiftRows,
// optional MixColumns, then a column-major byte stream out with backpressure.
module aes_state_round_ctrl #(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input logic                   CLK,
    input logic                   RST,
    aes_state_round_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MIX, READ, OUT} state_t;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_SHIFT = 2'b10;
    localparam logic [1:0] CMD_MIX   = 2'b11;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state, state_nxt;
    logic [3:0]       k, k_nxt;
    logic [CNT_W-1:0] wd_cnt, wd_nxt;
    logic             last_q, last_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             stall;
    logic [3:0]       byte_add;

    // Column-major byte index k maps to memory address {row, col}.
    assign byte_add = {k[1:0], k[3:2]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            k      <= '0;
            wd_cnt <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            wd_cnt <= wd_nxt;
            last_q <= last_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        wd_nxt        = '0;
        last_nxt      = last_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        stall         = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.mem_cs    = 1'b0;
        bus.mem_rwsm  = CMD_READ;
        bus.mem_add   = '0;
        bus.mem_din   = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    last_nxt  = bus.last_round;
                    k_nxt     = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.mem_cs   = 1'b1;
                    bus.mem_rwsm = CMD_WRITE;
                    bus.mem_din  = bus.in_data;
                    bus.mem_add  = byte_add;
                    k_nxt        = k + 4'd1;
                    if (k == 4'd15) state_nxt = SHIFT;
                end else begin
                    stall = 1'b1;
                end
            end
            SHIFT: begin
                bus.mem_cs   = 1'b1;
                bus.mem_rwsm = CMD_SHIFT;
                state_nxt    = last_q ? READ : MIX;
            end
            MIX: begin
                bus.mem_cs   = 1'b1;
                bus.mem_rwsm = CMD_MIX;
                state_nxt    = READ;
            end
            READ: begin
                bus.mem_cs   = 1'b1;
                bus.mem_rwsm = CMD_READ;
                bus.mem_add  = byte_add;
                state_nxt    = OUT;
            end
            OUT: begin
                // No read is issued here, so the registered mem_dout holds steady.
                bus.out_valid = 1'b1;
                bus.out_data  = bus.mem_dout;
                if (bus.out_ready) begin
                    k_nxt = k + 4'd1;
                    if (k == 4'd15) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = READ;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (TIMEOUT > 0 && stall) begin
            if (wd_cnt == WD_LAST) begin
                state_nxt = IDLE;
                k_nxt     = '0;
                err_nxt   = 1'b1;
            end else begin
                wd_nxt = wd_cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_aes_state_round_ctrl.sv
// Bench for aes_state_round_ctrl: behavioural AES state memory plus a byte scoreboard.
module tb_aes_state_round_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    aes_state_round_ctrl_if bus ();

    aes_state_round_ctrl #(.TIMEOUT(5), .CNT_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;
    int mix_cnt  = 0;
    int out_cnt  = 0;

    logic [7:0] exp_q   [$];
    logic [5:0] trace_q [$];
    logic [7:0] mem [16];
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] mon_exp;

    logic [7:0] in_vec [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                                8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    logic [7:0] exp_mix [16] = '{8'h04, 8'h66, 8'h81, 8'he5, 8'he0, 8'hcb, 8'h19, 8'h9a,
                                 8'h48, 8'hf8, 8'hd3, 8'h7a, 8'h28, 8'h06, 8'h26, 8'h4c};
    logic [7:0] exp_fin [16] = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv;
        r = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    // Behavioural state memory, address {row, col}.
    always @(posedge CLK) begin
        if (bus.mem_cs === 1'b1) begin
            case (bus.mem_rwsm)
                2'b00: bus.mem_dout <= mem[bus.mem_add];
                2'b01: mem[bus.mem_add] <= sbox(bus.mem_din);
                2'b10: begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            mem[4'(r*4 + c)] <= mem[4'(r*4 + ((c + r) % 4))];
                end
                default: begin
                    for (int c = 0; c < 4; c++) begin
                        mem[4'(c)]      <= xt(mem[4'(c)]) ^ xt(mem[4'(4+c)]) ^ mem[4'(4+c)]
                                           ^ mem[4'(8+c)] ^ mem[4'(12+c)];
                        mem[4'(4+c)]    <= mem[4'(c)] ^ xt(mem[4'(4+c)]) ^ xt(mem[4'(8+c)])
                                           ^ mem[4'(8+c)] ^ mem[4'(12+c)];
                        mem[4'(8+c)]    <= mem[4'(c)] ^ mem[4'(4+c)] ^ xt(mem[4'(8+c)])
                                           ^ xt(mem[4'(12+c)]) ^ mem[4'(12+c)];
                        mem[4'(12+c)]   <= xt(mem[4'(c)]) ^ mem[4'(c)] ^ mem[4'(4+c)]
                                           ^ mem[4'(8+c)] ^ xt(mem[4'(12+c)]);
                    end
                end
            endcase
        end
    end

    // Monitor: command trace, output scoreboard, hold stability, done/err exclusivity.
    always @(negedge CLK) begin
        if (RST !== 1'b0) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.mem_cs === 1'b1) begin
                trace_q.push_back({bus.mem_rwsm, bus.mem_add});
                if (bus.mem_rwsm === 2'b11) mix_cnt++;
            end
            if (bus.out_valid === 1'b1 && prev_stall) begin
                chk_cnt++;
                if (bus.out_data !== prev_data)
                    $display("FAIL out_hold: out_data=%h changed from %h while stalled", bus.out_data, prev_data);
                else pass_cnt++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                chk_cnt++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_byte: got %h with no byte expected", bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.out_data !== mon_exp)
                        $display("FAIL out_byte: got %h expected %h", bus.out_data, mon_exp);
                    else pass_cnt++;
                end
            end
            if (bus.done === 1'b1) done_cnt++;
            if (bus.done === 1'b1 || bus.err === 1'b1) begin
                chk_cnt++;
                if (bus.done === 1'b1 && bus.err === 1'b1)
                    $display("FAIL done_err_excl: done=%b err=%b required not both", bus.done, bus.err);
                else pass_cnt++;
            end
            prev_stall <= (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_data  <= bus.out_data;
        end
    end

    // Runs one round from IDLE; returns ok=0 if done never arrives.
    task automatic do_round(input bit last, input int gap_max, input bit bp, input bit poke, output bit ok);
        int d0;
        int o0;
        int lowrun;
        bit poked;
        d0 = done_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 16; i++) exp_q.push_back(last ? exp_fin[i] : exp_mix[i]);
        bus.start      = 1'b1;
        bus.last_round = last;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    bus.in_valid = 1'b0;
                    @(posedge CLK); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = in_vec[i];
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        ok     = 1'b0;
        lowrun = 0;
        poked  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            if (bp && lowrun < 3 && $urandom_range(1, 0) == 0) begin
                bus.out_ready = 1'b0;
                lowrun++;
            end else begin
                bus.out_ready = 1'b1;
                lowrun = 0;
            end
            if (poke && !poked && bus.out_valid === 1'b1 && (out_cnt - o0) >= 5) begin
                bus.start = 1'b1;
                poked     = 1'b1;
            end
            @(posedge CLK); #1;
            bus.start = 1'b0;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        chk_cnt++; if (bus.mem_cs !== 1'b0) $display("FAIL rst_mem_cs: got %b want 0", bus.mem_cs); else pass_cnt++;
        chk_cnt++; if (bus.mem_rwsm !== 2'b00) $display("FAIL rst_mem_rwsm: got %b want 00", bus.mem_rwsm); else pass_cnt++;
        chk_cnt++; if (bus.mem_add !== 4'h0) $display("FAIL rst_mem_add: got %h want 0", bus.mem_add); else pass_cnt++;
        chk_cnt++; if (bus.mem_din !== 8'h00) $display("FAIL rst_mem_din: got %h want 00", bus.mem_din); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else pass_cnt++;
        chk_cnt++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err); else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_full_round();
        bit ok;
        int d0, m0, o0;
        d0 = done_cnt; m0 = mix_cnt; o0 = out_cnt;
        do_round(1'b0, 0, 1'b0, 1'b0, ok);
        chk_cnt++; if (!ok) $display("FAIL full_done_timeout: no done within budget"); else pass_cnt++;
        repeat (3) @(posedge CLK); #1;
        chk_cnt++; if (out_cnt - o0 != 16) $display("FAIL full_out_count: got %0d want 16", out_cnt - o0); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL full_leftover: got %0d want 0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (mix_cnt - m0 != 1) $display("FAIL full_mix_count: got %0d want 1", mix_cnt - m0); else pass_cnt++;
        chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL full_idle: busy=%b want 0", bus.busy); else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_final_round();
        bit ok;
        int d0, m0, o0;
        d0 = done_cnt; m0 = mix_cnt; o0 = out_cnt;
        do_round(1'b1, 0, 1'b0, 1'b0, ok);
        chk_cnt++; if (!ok) $display("FAIL final_done_timeout: no done within budget"); else pass_cnt++;
        repeat (3) @(posedge CLK); #1;
        chk_cnt++; if (out_cnt - o0 != 16) $display("FAIL final_out_count: got %0d want 16", out_cnt - o0); else pass_cnt++;
        chk_cnt++; if (mix_cnt - m0 != 0) $display("FAIL final_no_mix: got %0d mix cmds want 0", mix_cnt - m0); else pass_cnt++;
        chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL final_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        int d0, o0;
        d0 = done_cnt; o0 = out_cnt;
        do_round(1'b0, 3, 1'b1, 1'b0, ok);
        chk_cnt++; if (!ok) $display("FAIL bp_done_timeout: no done within budget"); else pass_cnt++;
        repeat (3) @(posedge CLK); #1;
        chk_cnt++; if (out_cnt - o0 != 16) $display("FAIL bp_out_count: got %0d want 16", out_cnt - o0); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_command_trace();
        bit ok;
        logic [5:0] got;
        logic [1:0] cmd;
        logic [3:0] add;
        int bi;
        trace_q.delete();
        do_round(1'b0, 2, 1'b0, 1'b0, ok);
        chk_cnt++; if (!ok) $display("FAIL trace_done_timeout: no done within budget"); else pass_cnt++;
        chk_cnt++;
        if (trace_q.size() != 34) $display("FAIL trace_len: got %0d cmds want 34", trace_q.size());
        else pass_cnt++;
        for (int j = 0; j < 34 && j < trace_q.size(); j++) begin
            got = trace_q[j];
            bi  = (j < 16) ? j : j - 18;
            add = 4'((bi % 4) * 4 + (bi / 4));
            cmd = (j < 16) ? 2'b01 : (j == 16) ? 2'b10 : (j == 17) ? 2'b11 : 2'b00;
            chk_cnt++;
            if (got[5:4] !== cmd || (j != 16 && j != 17 && got[3:0] !== add))
                $display("FAIL trace_cmd[%0d]: got rwsm=%b add=%0d want rwsm=%b add=%0d", j, got[5:4], got[3:0], cmd, add);
            else pass_cnt++;
        end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        bit ok;
        int d0;
        d0 = done_cnt;
        bus.start = 1'b1; bus.last_round = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = in_vec[i];
            @(posedge CLK); #1;
        end
        bus.in_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", bus.in_ready); else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk_cnt++; if (done_cnt != d0) $display("FAIL abort_no_done: got %0d done want 0", done_cnt - d0); else pass_cnt++;
        exp_q.delete();
        do_round(1'b0, 1, 1'b0, 1'b0, ok);
        chk_cnt++; if (!ok) $display("FAIL abort_rerun_timeout: no done within budget"); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL abort_rerun_leftover: got %0d want 0", exp_q.size()); else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge CLK); #1;
    endtask

    task automatic test_watchdog();
        int d0;
        d0 = done_cnt;
        bus.start = 1'b1; bus.last_round = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk_cnt++;
            if (bus.err !== ((i == 5) ? 1'b1 : 1'b0))
                $display("FAIL wd_err[%0d]: got %b want %b", i, bus.err, (i == 5));
            else pass_cnt++;
        end
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL wd_idle: busy=%b want 0", bus.busy); else pass_cnt++;
        @(posedge CLK);
        @(negedge CLK);
        chk_cnt++; if (bus.err !== 1'b0) $display("FAIL wd_err_pulse: got %b want 0", bus.err); else pass_cnt++;
        chk_cnt++; if (done_cnt != d0) $display("FAIL wd_no_done: got %0d done want 0", done_cnt - d0); else pass_cnt++;
        @(posedge CLK); #1;
    endtask

    task automatic test_ignored_start();
        bit ok;
        int d0;
        d0 = done_cnt;
        do_round(1'b0, 0, 1'b1, 1'b1, ok);
        chk_cnt++; if (!ok) $display("FAIL ign_done_timeout: no done within budget"); else pass_cnt++;
        repeat (4) @(posedge CLK); #1;
        chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL ign_done_count: got %0d want 1", done_cnt - d0); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL ign_restart: busy=%b want 0", bus.busy); else pass_cnt++;
        exp_q.delete();
    endtask

    initial begin
        RST            = 1'b1;
        bus.start      = 1'b0;
        bus.last_round = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.out_ready  = 1'b0;
        bus.mem_dout   = 8'h00;
        test_reset();
        test_full_round();
        test_final_round();
        test_backpressure();
        test_command_trace();
        test_reset_abort();
        test_watchdog();
        test_ignored_start();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
